// File: rtl/sparc_control_unit_pkg.sv
// sparc_control_unit_pkg: state encodings, mux-select codes, instruction fields and trap types
// shared by the SPARC microsequencer and its decoder.
package sparc_control_unit_pkg;
   typedef enum logic [4:0] {
      S_RESET  = 5'd0,  S_FETCH  = 5'd1,  S_FWAIT  = 5'd2,  S_IRLD   = 5'd3,
      S_PCADV  = 5'd4,  S_DECODE = 5'd5,  S_CALL   = 5'd6,  S_BRANCH = 5'd7,
      S_TICC   = 5'd8,  S_ALU    = 5'd9,  S_LDADDR = 5'd10, S_LWAIT  = 5'd11,
      S_STADDR = 5'd12, S_LDWB   = 5'd13, S_TRAP   = 5'd14, S_SWAIT  = 5'd15
   } state_e;

   localparam logic [1:0] OP_FMT2  = 2'b00;
   localparam logic [1:0] OP_CALL  = 2'b01;
   localparam logic [1:0] OP_ARITH = 2'b10;
   localparam logic [2:0] OP2_BICC  = 3'b010;
   localparam logic [2:0] OP2_SETHI = 3'b100;
   localparam logic [5:0] OP3_TICC  = 6'b111010;

   localparam logic [1:0] MP_NPC     = 2'b01;
   localparam logic [1:0] MP_TBR     = 2'b10;
   localparam logic [1:0] MNP_INC4   = 2'b01;
   localparam logic [1:0] MNP_DISP30 = 2'b10;
   localparam logic [1:0] MNP_DISP22 = 2'b11;
   localparam logic [1:0] MB_REG     = 2'b00;
   localparam logic [1:0] MB_IMM     = 2'b01;
   localparam logic [1:0] MB_SETHI   = 2'b10;
   localparam logic [1:0] MSC_R15    = 2'b11;
   localparam logic [5:0] ALU_ADD    = 6'h00;

   localparam logic [1:0] TYPE_BYTE = 2'b00;
   localparam logic [1:0] TYPE_HALF = 2'b01;
   localparam logic [1:0] TYPE_WORD = 2'b10;

   localparam logic [7:0] TT_FETCH_TO = 8'h01;
   localparam logic [7:0] TT_ILLEGAL  = 8'h02;
   localparam logic [7:0] TT_MEM_TO   = 8'h09;

   // op3[1:0] size field: 00 word, 01 unsigned byte, 10 unsigned half, 11 doubleword (word beats)
   function automatic logic [1:0] mem_type(input logic [1:0] sz);
      return (sz == 2'b01) ? TYPE_BYTE : (sz == 2'b10) ? TYPE_HALF : TYPE_WORD;
   endfunction
endpackage

// File: rtl/sparc_control_unit_decoder.sv
// sparc_control_unit_decoder: IR op/op3 to post-DECODE execute state and illegal-instruction trap type
module sparc_control_unit_decoder
   import sparc_control_unit_pkg::*;
(
   input  logic [1:0] op_i,
   input  logic [5:0] op3_i,
   output state_e     next_o,
   output logic [7:0] tt_o
);
   logic [2:0] op2;

   assign op2  = op3_i[5:3];
   assign tt_o = (next_o == S_TRAP) ? TT_ILLEGAL : 8'h00;

   always_comb begin
      next_o = S_TRAP;
      case (op_i)
         OP_FMT2:  next_o = (op2 == OP2_BICC) ? S_BRANCH : (op2 == OP2_SETHI) ? S_ALU : S_TRAP;
         OP_CALL:  next_o = S_CALL;
         OP_ARITH: next_o = (op3_i == OP3_TICC) ? S_TICC : S_ALU;
         default:  next_o = op3_i[2] ? S_STADDR : S_LDADDR;
      endcase
   end
endmodule

// File: rtl/sparc_control_unit.sv
// sparc_control_unit: Moore microsequencer for the SPARC DataPath with a memory-wait
// watchdog and precise trap entry; all strobes decode from the registered state.
module sparc_control_unit
   import sparc_control_unit_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic [31:0] IR,
   input  logic        MOC,
   input  logic        BCOND,
   input  logic        TCOND,
   output logic        IR_Ld,
   output logic        MAR_Ld,
   output logic        MDR_Ld,
   output logic        WIM_Ld,
   output logic        TBR_Ld,
   output logic        TTR_Ld,
   output logic        PC_Ld,
   output logic        NPC_Ld,
   output logic        nPC_Clr,
   output logic        PSR_Ld,
   output logic        FR_Ld,
   output logic        Register_Windows_Enable,
   output logic        RF_Load_Enable,
   output logic        RF_Clear_Enable,
   output logic        RW,
   output logic        MOV,
   output logic [1:0]  Type,
   output logic [1:0]  MA,
   output logic [1:0]  MB,
   output logic [1:0]  MNP,
   output logic [1:0]  MP,
   output logic [1:0]  MS,
   output logic [1:0]  MSc,
   output logic        MC,
   output logic        MF,
   output logic        MM,
   output logic        MOP,
   output logic        MSa,
   output logic [5:0]  OpXX,
   output logic [7:0]  Trap_Type,
   output logic [4:0]  State
);
   state_e            state_q, state_d, dec_next;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [7:0]        tt_q, tt_d, dec_tt;
   logic              is_wait, expire, unused_ir;

   sparc_control_unit_decoder u_dec (
      .op_i   (IR[31:30]),
      .op3_i  (IR[24:19]),
      .next_o (dec_next),
      .tt_o   (dec_tt)
   );

   assign is_wait   = (state_q == S_FWAIT) || (state_q == S_LWAIT) || (state_q == S_SWAIT);
   assign expire    = is_wait && !MOC && (wait_q == WAIT_W'(MAX_WAIT));
   assign State     = state_q;
   assign Trap_Type = tt_q;
   assign unused_ir = ^{IR[29:25], IR[18:14], IR[12:7]};

   always_comb begin
      state_d = state_q;
      tt_d    = tt_q;
      wait_d  = is_wait ? wait_q + WAIT_W'(!MOC) : '0;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = S_FWAIT;
         S_FWAIT:  state_d = MOC ? S_IRLD : expire ? S_TRAP : S_FWAIT;
         S_IRLD:   state_d = S_PCADV;
         S_PCADV:  state_d = S_DECODE;
         S_DECODE: state_d = dec_next;
         S_TICC:   state_d = TCOND ? S_TRAP : S_FETCH;
         S_LDADDR: state_d = S_LWAIT;
         S_LWAIT:  state_d = MOC ? S_LDWB : expire ? S_TRAP : S_LWAIT;
         S_STADDR: state_d = S_SWAIT;
         S_SWAIT:  state_d = MOC ? S_FETCH : expire ? S_TRAP : S_SWAIT;
         default:  state_d = S_FETCH;
      endcase
      // TRAP always exits to FETCH, so this fires exactly once per trap entry
      if (state_d == S_TRAP)
         tt_d = (state_q == S_FWAIT)  ? TT_FETCH_TO :
                (state_q == S_DECODE) ? dec_tt :
                (state_q == S_TICC)   ? {1'b1, IR[6:0]} : TT_MEM_TO;
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_RESET;
         wait_q  <= '0;
         tt_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         tt_q    <= tt_d;
      end
   end

   always_comb begin
      {IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr, PSR_Ld, FR_Ld} = '0;
      {RF_Load_Enable, RF_Clear_Enable, RW, MOV, MC, MF, MM, MOP, MSa} = '0;
      {Type, MA, MB, MNP, MP, MS, MSc} = '0;
      OpXX = '0;
      Register_Windows_Enable = 1'b1;
      case (state_q)
         S_RESET:  {PC_Ld, nPC_Clr, RF_Clear_Enable, RF_Load_Enable} = 4'b1111;
         S_FETCH:  {MAR_Ld, MM} = 2'b11;
         S_FWAIT:  begin
            {MOV, RW, MDR_Ld, MF} = 4'b1111;
            Type = TYPE_WORD;
         end
         S_IRLD:   IR_Ld = 1'b1;
         S_PCADV:  begin
            {PC_Ld, NPC_Ld} = 2'b11;
            MP  = MP_NPC;
            MNP = MNP_INC4;
         end
         S_CALL:   begin
            {RF_Load_Enable, NPC_Ld} = 2'b11;
            MSc = MSC_R15;
            MNP = MNP_DISP30;
         end
         S_BRANCH: begin
            NPC_Ld = BCOND;
            MNP    = MNP_DISP22;
         end
         S_ALU:    begin
            RF_Load_Enable = 1'b1;
            OpXX  = IR[24:19];
            FR_Ld = IR[23];
            MB    = (IR[31:30] == OP_FMT2) ? MB_SETHI : IR[13] ? MB_IMM : MB_REG;
         end
         S_LDADDR: begin
            MAR_Ld = 1'b1;
            OpXX   = ALU_ADD;
         end
         S_LWAIT:  begin
            {MOV, RW, MDR_Ld, MF} = 4'b1111;
            Type = mem_type(IR[20:19]);
         end
         S_LDWB:   {RF_Load_Enable, MC} = 2'b11;
         S_STADDR: begin
            {MAR_Ld, MDR_Ld} = 2'b11;
            OpXX = ALU_ADD;
         end
         S_SWAIT:  begin
            MOV  = 1'b1;
            Type = mem_type(IR[20:19]);
         end
         S_TRAP:   begin
            {TBR_Ld, TTR_Ld, PC_Ld, nPC_Clr, PSR_Ld} = 5'b11111;
            MP = MP_TBR;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_sparc_control_unit.sv
// tb_sparc_control_unit: directed instruction sequences against hand-derived state walks,
// strobes and trap types; inputs change and outputs are sampled on the falling edge.
module tb_sparc_control_unit;
   logic        Clk = 1'b0, nReset = 1'b0, MOC = 1'b0, BCOND = 1'b0, TCOND = 1'b0;
   logic [31:0] IR = '0;
   logic        IR_Ld, MAR_Ld, MDR_Ld, WIM_Ld, TBR_Ld, TTR_Ld, PC_Ld, NPC_Ld, nPC_Clr, PSR_Ld, FR_Ld;
   logic        Register_Windows_Enable, RF_Load_Enable, RF_Clear_Enable, RW, MOV;
   logic        MC, MF, MM, MOP, MSa;
   logic [1:0]  Type, MA, MB, MNP, MP, MS, MSc;
   logic [5:0]  OpXX;
   logic [7:0]  Trap_Type;
   logic [4:0]  State;
   int          chk = 0, pass = 0;

   always #5 Clk = ~Clk;

   sparc_control_unit #(.MAX_WAIT(15), .WAIT_W(4)) dut (
      .Clk(Clk), .nReset(nReset), .IR(IR), .MOC(MOC), .BCOND(BCOND), .TCOND(TCOND),
      .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .WIM_Ld(WIM_Ld), .TBR_Ld(TBR_Ld),
      .TTR_Ld(TTR_Ld), .PC_Ld(PC_Ld), .NPC_Ld(NPC_Ld), .nPC_Clr(nPC_Clr), .PSR_Ld(PSR_Ld),
      .FR_Ld(FR_Ld), .Register_Windows_Enable(Register_Windows_Enable),
      .RF_Load_Enable(RF_Load_Enable), .RF_Clear_Enable(RF_Clear_Enable), .RW(RW), .MOV(MOV),
      .Type(Type), .MA(MA), .MB(MB), .MNP(MNP), .MP(MP), .MS(MS), .MSc(MSc), .MC(MC), .MF(MF),
      .MM(MM), .MOP(MOP), .MSa(MSa), .OpXX(OpXX), .Trap_Type(Trap_Type), .State(State)
   );

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      chk++; if ({State, Trap_Type} !== 13'd0) $display("FAIL reset_state got %0d/%h want 0/00", State, Trap_Type); else pass++;
      chk++; if ({PC_Ld, nPC_Clr, RF_Clear_Enable, RF_Load_Enable, Register_Windows_Enable, MOV} !== 6'b111110)
         $display("FAIL reset_strobes got %b want 111110", {PC_Ld, nPC_Clr, RF_Clear_Enable, RF_Load_Enable, Register_Windows_Enable, MOV}); else pass++;
      nReset = 1'b1;
      @(negedge Clk);
      chk++; if ({State, MAR_Ld, MM} !== {5'd1, 2'b11}) $display("FAIL reset_fetch got %0d/%b%b want 1/11", State, MAR_Ld, MM); else pass++;
      @(negedge Clk);
      chk++; if ({State, MOV} !== {5'd2, 1'b1}) $display("FAIL reset_fwait got %0d/%b want 2/1", State, MOV); else pass++;
      #2 nReset = 1'b0;
      #1;
      chk++; if ({State, MOV, PC_Ld, nPC_Clr} !== {5'd0, 3'b011}) $display("FAIL reset_async got %0d/%b%b%b want 0/011", State, MOV, PC_Ld, nPC_Clr); else pass++;
      repeat (2) @(negedge Clk);
      chk++; if (State !== 5'd0) $display("FAIL reset_hold got %0d want 0", State); else pass++;
      nReset = 1'b1;
      @(negedge Clk);
      chk++; if (State !== 5'd1) $display("FAIL reset_release got %0d want 1", State); else pass++;
   endtask

   task automatic test_alu();
      int seq[$] = '{2, 3, 4, 5, 9, 1};
      IR = 32'h8200_6005;
      MOC = 1'b1;
      foreach (seq[i]) begin
         @(negedge Clk);
         chk++; if (State !== 5'(seq[i])) $display("FAIL alu_state[%0d] got %0d want %0d", i, State, seq[i]); else pass++;
         if (i == 0) begin
            chk++; if ({MOV, RW, Type, MDR_Ld, MF} !== 6'b111011) $display("FAIL alu_fwait got %b want 111011", {MOV, RW, Type, MDR_Ld, MF}); else pass++;
         end
         if (i == 1) begin
            chk++; if (IR_Ld !== 1'b1) $display("FAIL alu_irld got %b want 1", IR_Ld); else pass++;
         end
         if (i == 2) begin
            chk++; if ({PC_Ld, MP, NPC_Ld, MNP} !== 6'b101101) $display("FAIL alu_pcadv got %b want 101101", {PC_Ld, MP, NPC_Ld, MNP}); else pass++;
         end
         if (i == 4) begin
            chk++; if ({RF_Load_Enable, OpXX, MB, FR_Ld} !== {1'b1, 6'h00, 2'b01, 1'b0})
               $display("FAIL alu_exec got %b/%h/%b/%b want 1/00/01/0", RF_Load_Enable, OpXX, MB, FR_Ld); else pass++;
         end
      end
   endtask

   task automatic test_load();
      int seq[$]  = '{2, 3, 4, 5, 10, 11, 11, 11, 13, 1};
      int mocv[$] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      IR = 32'hC200_6004;
      foreach (seq[i]) begin
         @(negedge Clk);
         chk++; if (State !== 5'(seq[i])) $display("FAIL ld_state[%0d] got %0d want %0d", i, State, seq[i]); else pass++;
         if (i == 4) begin
            chk++; if ({MAR_Ld, MM, OpXX} !== 8'b10_000000) $display("FAIL ld_addr got %b%b/%h want 10/00", MAR_Ld, MM, OpXX); else pass++;
         end
         if (i == 5) begin
            chk++; if ({MOV, RW, Type, MDR_Ld, MF} !== 6'b111011) $display("FAIL ld_wait got %b want 111011", {MOV, RW, Type, MDR_Ld, MF}); else pass++;
         end
         if (i == 8) begin
            chk++; if ({RF_Load_Enable, MC} !== 2'b11) $display("FAIL ld_wb got %b%b want 11", RF_Load_Enable, MC); else pass++;
         end
         MOC = mocv[i][0];
      end
   endtask

   task automatic test_store_timeout();
      int seq[$]  = '{2, 3, 4, 5, 12};
      int mocv[$] = '{1, 0, 0, 0, 0};
      IR = 32'hC220_6008;
      foreach (seq[i]) begin
         @(negedge Clk);
         chk++; if (State !== 5'(seq[i])) $display("FAIL st_state[%0d] got %0d want %0d", i, State, seq[i]); else pass++;
         MOC = mocv[i][0];
      end
      chk++; if ({MAR_Ld, MM, OpXX, MDR_Ld, MF} !== 10'b10_000000_10) $display("FAIL st_addr got %b want 1000000010", {MAR_Ld, MM, OpXX, MDR_Ld, MF}); else pass++;
      for (int k = 0; k < 16; k++) begin
         @(negedge Clk);
         chk++; if (State !== 5'd15) $display("FAIL st_swait[%0d] got %0d want 15", k, State); else pass++;
         if (k == 0) begin
            chk++; if ({MOV, RW, Type} !== 4'b1010) $display("FAIL st_bus got %b want 1010", {MOV, RW, Type}); else pass++;
         end
      end
      @(negedge Clk);
      chk++; if ({State, Trap_Type} !== {5'd14, 8'h09}) $display("FAIL st_trap got %0d/%h want 14/09", State, Trap_Type); else pass++;
      chk++; if ({TBR_Ld, TTR_Ld, PC_Ld, MP, nPC_Clr, PSR_Ld, MOV} !== 8'b1111_0110)
         $display("FAIL st_trap_strobes got %b want 11110110", {TBR_Ld, TTR_Ld, PC_Ld, MP, nPC_Clr, PSR_Ld, MOV}); else pass++;
      @(negedge Clk);
      chk++; if ({State, Trap_Type} !== {5'd1, 8'h09}) $display("FAIL st_after got %0d/%h want 1/09", State, Trap_Type); else pass++;
   endtask

   task automatic test_watchdog();
      IR = 32'h8200_6005;
      MOC = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge Clk);
         chk++; if (State !== 5'd2) $display("FAIL wd_fwait[%0d] got %0d want 2", k, State); else pass++;
         if (k == 15) MOC = 1'b1;
      end
      @(negedge Clk);
      chk++; if (State !== 5'd3) $display("FAIL wd_moc_wins got %0d want 3", State); else pass++;
      repeat (4) @(negedge Clk);
      chk++; if (State !== 5'd1) $display("FAIL wd_alu_done got %0d want 1", State); else pass++;
      MOC = 1'b0;
      repeat (16) @(negedge Clk);
      chk++; if (State !== 5'd2) $display("FAIL wd_fwait_last got %0d want 2", State); else pass++;
      @(negedge Clk);
      chk++; if ({State, Trap_Type} !== {5'd14, 8'h01}) $display("FAIL wd_fetch_trap got %0d/%h want 14/01", State, Trap_Type); else pass++;
      @(negedge Clk);
      chk++; if (State !== 5'd1) $display("FAIL wd_after got %0d want 1", State); else pass++;
   endtask

   task automatic test_branch();
      int seq[$] = '{2, 3, 4, 5, 7, 1};
      IR = 32'h1280_0004;
      MOC = 1'b1;
      for (int b = 1; b >= 0; b--) begin
         BCOND = b[0];
         foreach (seq[i]) begin
            @(negedge Clk);
            chk++; if (State !== 5'(seq[i])) $display("FAIL br%0d_state[%0d] got %0d want %0d", b, i, State, seq[i]); else pass++;
            if (i == 4) begin
               chk++; if ({NPC_Ld, MNP} !== {b[0], 2'b11}) $display("FAIL br%0d_npc got %b%b want %b11", b, NPC_Ld, MNP, b[0]); else pass++;
            end
         end
      end
   endtask

   task automatic test_call_sethi();
      int seq[$] = '{2, 3, 4, 5, 6, 1};
      IR = 32'h4000_0010;
      foreach (seq[i]) begin
         @(negedge Clk);
         chk++; if (State !== 5'(seq[i])) $display("FAIL call_state[%0d] got %0d want %0d", i, State, seq[i]); else pass++;
         if (i == 4) begin
            chk++; if ({RF_Load_Enable, MC, MSc, NPC_Ld, MNP} !== 7'b1011110) $display("FAIL call_strobes got %b want 1011110", {RF_Load_Enable, MC, MSc, NPC_Ld, MNP}); else pass++;
         end
      end
      IR = 32'h0300_0010;
      repeat (5) @(negedge Clk);
      chk++; if ({State, RF_Load_Enable, MB} !== {5'd9, 3'b110}) $display("FAIL sethi got %0d/%b/%b want 9/1/10", State, RF_Load_Enable, MB); else pass++;
      @(negedge Clk);
      chk++; if (State !== 5'd1) $display("FAIL sethi_done got %0d want 1", State); else pass++;
   endtask

   task automatic test_traps();
      int tseq[$] = '{2, 3, 4, 5, 8, 14, 1};
      IR = 32'h91D0_2003;
      TCOND = 1'b1;
      foreach (tseq[i]) begin
         @(negedge Clk);
         chk++; if (State !== 5'(tseq[i])) $display("FAIL ticc_state[%0d] got %0d want %0d", i, State, tseq[i]); else pass++;
         if (i == 5) begin
            chk++; if (Trap_Type !== 8'h83) $display("FAIL ticc_tt got %h want 83", Trap_Type); else pass++;
         end
      end
      TCOND = 1'b0;
      repeat (6) @(negedge Clk);
      chk++; if ({State, Trap_Type} !== {5'd1, 8'h83}) $display("FAIL ticc_untaken got %0d/%h want 1/83", State, Trap_Type); else pass++;
      IR = 32'h0180_0000;
      repeat (5) @(negedge Clk);
      chk++; if ({State, Trap_Type} !== {5'd14, 8'h02}) $display("FAIL illegal got %0d/%h want 14/02", State, Trap_Type); else pass++;
      @(negedge Clk);
      chk++; if (State !== 5'd1) $display("FAIL illegal_after got %0d want 1", State); else pass++;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store_timeout();
      test_watchdog();
      test_branch();
      test_call_sethi();
      test_traps();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule
